// File: rtl/sort_packet_buffer.sv
// ----------------------------------------------------------------------------
// sort_packet_buffer
//   Upstream stage of the packet sorter. Packets (sop/eop/val framed) are
//   written into a circular word RAM and become visible to the output side
//   only once their eop word has been stored. Committed packets are replayed
//   one whole packet at a time as contiguous bursts, launched only while the
//   sorter reports idle. Malformed, oversized and overflowing packets are
//   discarded and reported with a one-cycle drop_o pulse.
//
// Parameters
//   DWIDTH      data word width
//   AWIDTH      sorter address width; longest packet is 2**AWIDTH words
//   BUF_AWIDTH  buffer RAM address width (>= AWIDTH); one RAM word is always
//               left unused so a full ring never looks like an empty one
//
// Ports
//   clk_i, arst_i            clock (rising edge), async active-high reset
//   data_i/sop_i/eop_i/val_i input packet stream
//   data_o/sop_o/eop_o/val_o output packet stream to the sorter
//   busy_i                   sorter busy; new bursts start only while low
//   drop_o                   one-cycle pulse per discarded packet
//
// Build option
//   SORT_PKT_BUF_STATS_EN    adds pkt_cnt_o / drop_cnt_o saturating counters
// ----------------------------------------------------------------------------
module sort_packet_buffer #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned AWIDTH     = 8,
    parameter int unsigned BUF_AWIDTH = 10
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    input  logic              busy_i,
    output logic              drop_o
`ifdef SORT_PKT_BUF_STATS_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_HOLD} state_t;

    localparam logic [BUF_AWIDTH-1:0] PTR_ONE = BUF_AWIDTH'(1);
    localparam logic [BUF_AWIDTH:0]   CNT_ONE = (BUF_AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0]       LEN_ONE = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0]       MAX_LEN = {1'b1, {AWIDTH{1'b0}}};

    // RAM word: {eop_flag, data}
    logic [DWIDTH:0]     ram_q [2**BUF_AWIDTH];
    logic [DWIDTH:0]     rdata_q;

    logic [BUF_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_AWIDTH-1:0] cm_ptr_q, cm_ptr_d;
    logic [BUF_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]       len_q, len_d;
    logic                  open_q, open_d;
    logic [BUF_AWIDTH:0]   cnt_q, cnt_d;
    logic                  drop_q, drop_d;

    state_t                state_q, state_d;
    logic                  hold_q, hold_d;
    logic                  first_q, first_d;
    logic [DWIDTH-1:0]     data_q, data_d;
    logic                  sop_q, sop_d, eop_q, eop_d, val_q, val_d;

    logic                  we, rd_en, commit, pop;
    logic [BUF_AWIDTH-1:0] waddr;

    // ---------------- write side ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        len_d    = len_q;
        open_d   = open_q;
        drop_d   = 1'b0;
        commit   = 1'b0;
        we       = 1'b0;
        waddr    = wr_ptr_q;
        if (val_i) begin
            if (sop_i) begin
                // A still-open packet is abandoned: rewinding to cm_ptr
                // happens implicitly because the new packet starts there.
                drop_d = open_q;
                if (cm_ptr_q + PTR_ONE == rd_ptr_q) begin
                    drop_d   = 1'b1;
                    open_d   = 1'b0;
                    len_d    = '0;
                    wr_ptr_d = cm_ptr_q;
                end else begin
                    we       = 1'b1;
                    waddr    = cm_ptr_q;
                    wr_ptr_d = cm_ptr_q + PTR_ONE;
                    if (eop_i) begin
                        commit   = 1'b1;
                        cm_ptr_d = cm_ptr_q + PTR_ONE;
                        open_d   = 1'b0;
                        len_d    = '0;
                    end else begin
                        open_d = 1'b1;
                        len_d  = LEN_ONE;
                    end
                end
            end else if (open_q) begin
                // Any word beyond the maximum length (even an eop) is oversize.
                if (len_q == MAX_LEN || wr_ptr_q + PTR_ONE == rd_ptr_q) begin
                    drop_d   = 1'b1;
                    open_d   = 1'b0;
                    len_d    = '0;
                    wr_ptr_d = cm_ptr_q;
                end else begin
                    we       = 1'b1;
                    waddr    = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (eop_i) begin
                        commit   = 1'b1;
                        cm_ptr_d = wr_ptr_q + PTR_ONE;
                        open_d   = 1'b0;
                        len_d    = '0;
                    end else begin
                        len_d = len_q + LEN_ONE;
                    end
                end
            end
        end
    end

    // ---------------- output FSM ----------------
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        first_d  = first_q;
        rd_ptr_d = rd_ptr_q;
        rd_en    = 1'b0;
        pop      = 1'b0;
        val_d    = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0 && !busy_i) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    first_d  = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                // rdata_q holds the word fetched one cycle earlier.
                val_d   = 1'b1;
                sop_d   = first_q;
                first_d = 1'b0;
                data_d  = rdata_q[DWIDTH-1:0];
                if (rdata_q[DWIDTH]) begin
                    eop_d   = 1'b1;
                    pop     = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
            end
            ST_HOLD: begin
                hold_d = ~hold_q;
                if (hold_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (commit && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!commit && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            ram_q[waddr] <= {eop_i, data_i};
        end
        if (rd_en) begin
            rdata_q <= ram_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            open_q   <= 1'b0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            state_q  <= ST_IDLE;
            hold_q   <= 1'b0;
            first_q  <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            val_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            open_q   <= open_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            first_q  <= first_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            val_q    <= val_d;
        end
    end

    assign data_o = data_q;
    assign sop_o  = sop_q;
    assign eop_o  = eop_q;
    assign val_o  = val_q;
    assign drop_o = drop_q;

`ifdef SORT_PKT_BUF_STATS_EN
    logic [15:0] pkt_cnt_q, drop_cnt_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop && pkt_cnt_q != '1) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (drop_d && drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_sort_packet_buffer.sv
// Testbench for sort_packet_buffer.
// dut_a: AWIDTH=2, BUF_AWIDTH=4 (4-word max packet, 16-word ring).
// dut_b: AWIDTH=4, BUF_AWIDTH=4 (16-word max packet, 16-word ring, 15 usable).
// Both share the input stream; 'sel' picks which one the scoreboard watches.
module tb_sort_packet_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       sop, eop, val, busy;

    logic [7:0] a_data, b_data;
    logic       a_sop, a_eop, a_val, a_drop;
    logic       b_sop, b_eop, b_val, b_drop;

    always #5 clk = ~clk;

    sort_packet_buffer #(.DWIDTH(8), .AWIDTH(2), .BUF_AWIDTH(4)) dut_a (
        .clk_i(clk), .arst_i(rst), .data_i(data), .sop_i(sop), .eop_i(eop),
        .val_i(val), .data_o(a_data), .sop_o(a_sop), .eop_o(a_eop),
        .val_o(a_val), .busy_i(busy), .drop_o(a_drop)
    );

    sort_packet_buffer #(.DWIDTH(8), .AWIDTH(4), .BUF_AWIDTH(4)) dut_b (
        .clk_i(clk), .arst_i(rst), .data_i(data), .sop_i(sop), .eop_i(eop),
        .val_i(val), .data_o(b_data), .sop_o(b_sop), .eop_o(b_eop),
        .val_o(b_val), .busy_i(busy), .drop_o(b_drop)
    );

    typedef struct packed {
        logic       s;
        logic       e;
        logic [7:0] d;
    } word_t;

    typedef struct {
        int len;
        bit ws;
        bit we;
        bit emit;
        int drop;
    } vec_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    sel = 1'b0;
    int    drops_a = 0, drops_b = 0, vcnt = 0;
    int    first_sop_cyc = -1, last_eop_cyc = -1, min_gap = 1000;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: samples on the falling edge.
    word_t mon_act, mon_exp;
    logic  mon_v;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_drop) drops_a++;
            if (b_drop) drops_b++;
            mon_v   = sel ? b_val : a_val;
            mon_act = sel ? {b_sop, b_eop, b_data} : {a_sop, a_eop, a_data};
            if (mon_v) begin
                vcnt++;
                if (mon_act.s) begin
                    if (first_sop_cyc < 0) first_sop_cyc = cyc;
                    if (last_eop_cyc >= 0 && (cyc - last_eop_cyc - 1) < min_gap)
                        min_gap = cyc - last_eop_cyc - 1;
                end
                if (mon_act.e) last_eop_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got sop=%0b eop=%0b data=%0h, required no output",
                             mon_act.s, mon_act.e, mon_act.d);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL out_word: got sop=%0b eop=%0b data=%0h, required sop=%0b eop=%0b data=%0h",
                                 mon_act.s, mon_act.e, mon_act.d, mon_exp.s, mon_exp.e, mon_exp.d);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [7:0] d, input logic s, input logic e);
        data = d; sop = s; eop = e; val = 1'b1;
        @(posedge clk);
        #1;
        val = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic drive_pkt(input int len, input bit ws, input bit we, input bit push);
        for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            logic       s, e;
            d = 8'($urandom_range(0, 255));
            s = ws && (k == 0);
            e = we && (k == len - 1);
            if (push) exp_q.push_back({s, e, d});
            drive_word(d, s, e);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            idle(1);
            n++;
        end
        check("drain_pending_words", exp_q.size(), 0);
        exp_q.delete();
        idle(10);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
        last_eop_cyc = -1;
        idle(1);
    endtask

    vec_t tbl[9];
    int   d0, v0, eop_cyc, total, n, len;

    initial begin
        tbl[0] = '{len: 1, ws: 1, we: 1, emit: 1, drop: 0};  // sop&eop single word
        tbl[1] = '{len: 4, ws: 1, we: 1, emit: 1, drop: 0};  // exactly max length
        tbl[2] = '{len: 5, ws: 1, we: 1, emit: 0, drop: 1};  // oversize
        tbl[3] = '{len: 4, ws: 1, we: 1, emit: 1, drop: 0};  // passes after oversize
        tbl[4] = '{len: 3, ws: 1, we: 0, emit: 0, drop: 0};  // left open
        tbl[5] = '{len: 3, ws: 1, we: 1, emit: 1, drop: 1};  // new sop drops open one
        tbl[6] = '{len: 2, ws: 0, we: 1, emit: 0, drop: 0};  // no sop: silent discard
        tbl[7] = '{len: 6, ws: 1, we: 1, emit: 0, drop: 1};  // oversize, tail discarded
        tbl[8] = '{len: 2, ws: 1, we: 1, emit: 1, drop: 0};

        rst = 1'b1; data = '0; sop = 1'b0; eop = 1'b0; val = 1'b0; busy = 1'b0;
        idle(3);
        check("rst_val", a_val, 0);
        check("rst_sop", a_sop, 0);
        check("rst_eop", a_eop, 0);
        check("rst_data", a_data, 0);
        check("rst_drop", a_drop, 0);
        rst = 1'b0;
        idle(2);

        // Basic packet with latency measurement.
        first_sop_cyc = -1;
        exp_q.push_back({1'b1, 1'b0, 8'd5});
        exp_q.push_back({1'b0, 1'b0, 8'd3});
        exp_q.push_back({1'b0, 1'b0, 8'd9});
        exp_q.push_back({1'b0, 1'b1, 8'd1});
        drive_word(8'd5, 1'b1, 1'b0);
        drive_word(8'd3, 1'b0, 1'b0);
        drive_word(8'd9, 1'b0, 1'b0);
        drive_word(8'd1, 1'b0, 1'b1);
        eop_cyc = cyc;
        wait_drain(50);
        check("basic_sop_latency", first_sop_cyc - eop_cyc, 2);

        // Table-driven packet vectors on dut_a.
        for (int i = 0; i < 9; i++) begin
            d0 = drops_a;
            drive_pkt(tbl[i].len, tbl[i].ws, tbl[i].we, tbl[i].emit);
            wait_drain(100);
            check($sformatf("tbl%0d_drops", i), drops_a - d0, tbl[i].drop);
        end

        // Busy hold: three stored packets, released in order with gaps.
        busy = 1'b1;
        v0 = vcnt;
        drive_pkt(2, 1, 1, 1);
        drive_pkt(3, 1, 1, 1);
        drive_pkt(1, 1, 1, 1);
        idle(20);
        check("busy_no_output", vcnt - v0, 0);
        min_gap = 1000;
        last_eop_cyc = -1;
        busy = 1'b0;
        wait_drain(200);
        check("busy_words_out", vcnt - v0, 6);
        check("busy_gap_ge2", (min_gap >= 2) ? 1 : 0, 1);

        // Overflow on dut_b: 15 usable words, third 6-word packet cannot fit.
        reset_all();
        sel = 1'b1;
        busy = 1'b1;
        d0 = drops_b;
        drive_pkt(6, 1, 1, 1);
        drive_pkt(6, 1, 1, 1);
        drive_pkt(6, 1, 1, 0);
        idle(5);
        check("ovf_drops", drops_b - d0, 1);
        v0 = vcnt;
        busy = 1'b0;
        wait_drain(200);
        check("ovf_words_out", vcnt - v0, 12);
        drive_pkt(5, 1, 1, 1);
        wait_drain(100);
        check("ovf_recover_drops", drops_b - d0, 1);
        sel = 1'b0;

        // Wrap: 100 random packets through the 16-word ring of dut_a.
        reset_all();
        d0 = drops_a;
        v0 = vcnt;
        total = 0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 4);
            drive_pkt(len, 1, 1, 1);
            total += len;
            idle(len + 6);
        end
        wait_drain(200);
        check("wrap_drops", drops_a - d0, 0);
        check("wrap_words_out", vcnt - v0, total);

        // Async reset in the middle of a burst.
        drive_pkt(4, 1, 1, 1);
        drive_pkt(3, 1, 1, 1);
        n = 0;
        while (!a_val && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_send_reached", a_val, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_val", a_val, 0);
        check("arst_sop", a_sop, 0);
        check("arst_eop", a_eop, 0);
        check("arst_data", a_data, 0);
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        last_eop_cyc = -1;
        v0 = vcnt;
        idle(20);
        check("arst_buffer_empty", vcnt - v0, 0);
        d0 = drops_a;
        drive_pkt(2, 0, 1, 0);
        idle(10);
        check("arst_nosop_drops", drops_a - d0, 0);
        check("arst_nosop_out", vcnt - v0, 0);
        drive_pkt(3, 1, 1, 1);
        wait_drain(50);
        check("arst_next_pkt_out", vcnt - v0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
